// File: rtl/hazard_if.sv
// Hazard-control bundle between the 5-stage pipeline datapath (master) and the
// hazard controller (slave): decoded ID/EX fields in, stall/flush/forward controls out.
interface hazard_if #(
   parameter int CNT_W = 32
);
   logic             id_valid;
   logic [4:0]       id_rs1;
   logic [4:0]       id_rs2;
   logic             ex_valid;
   logic [4:0]       ex_dst;
   logic             ex_wr;
   logic             ex_is_load;
   logic             ex_taken;
   logic             mem_busy;
   logic             stall_if;
   logic             stall_id;
   logic             bubble_ex;
   logic             freeze;
   logic             flush_if;
   logic             flush_id;
   logic [1:0]       fwd_rs1;
   logic [1:0]       fwd_rs2;
   logic [CNT_W-1:0] cnt_stall;
   logic [CNT_W-1:0] cnt_flush;

   modport master (
      output id_valid, id_rs1, id_rs2, ex_valid, ex_dst, ex_wr, ex_is_load,
             ex_taken, mem_busy,
      input  stall_if, stall_id, bubble_ex, freeze, flush_if, flush_id,
             fwd_rs1, fwd_rs2, cnt_stall, cnt_flush
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, ex_valid, ex_dst, ex_wr, ex_is_load,
             ex_taken, mem_busy,
      output stall_if, stall_id, bubble_ex, freeze, flush_if, flush_id,
             fwd_rs1, fwd_rs2, cnt_stall, cnt_flush
   );
endinterface

// File: rtl/hazard_controller.sv
// Stall/bubble/flush/forwarding sequencer for the 5-stage core, with MEM/WB
// destination shadows and wrap-around stall/flush event counters.
module hazard_controller #(
   parameter int CNT_W = 32
) (
   input  logic    clk,
   input  logic    rstd,
   hazard_if.slave hz
);
   typedef enum logic [1:0] {RUN, LDSTALL, MEMWAIT} state_t;

   state_t           state, state_nxt;
   logic             load_use, take;
   logic             stall_c, bubble_c, freeze_c, flush_c;
   logic [4:0]       mem_dst_p1, wb_dst_p2;
   logic             mem_wr_p1, mem_ld_p1, wb_wr_p2, wb_ld_p2;
   logic [1:0]       fwd_rs1_p1, fwd_rs2_p1;
   logic [CNT_W-1:0] cnt_stall_q, cnt_flush_q;
   logic             unused_wb;

   function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic ex_hit,
                                          input logic [4:0] ex_dst, input logic mem_hit,
                                          input logic [4:0] mem_dst);
      logic [1:0] sel;
      sel = 2'b00;
      if (rs != 5'd0) begin
         if (ex_hit && ex_dst == rs)        sel = 2'b01;
         else if (mem_hit && mem_dst == rs) sel = 2'b10;
      end
      return sel;
   endfunction

   assign load_use = hz.ex_valid & hz.ex_wr & hz.ex_is_load & (hz.ex_dst != 5'd0) &
                     hz.id_valid & ((hz.ex_dst == hz.id_rs1) | (hz.ex_dst == hz.id_rs2));
   assign take     = hz.ex_valid & hz.ex_taken;

   // Control decode: memory wait beats a taken branch, which beats a load-use stall
   always_comb begin
      stall_c   = 1'b0;
      bubble_c  = 1'b0;
      freeze_c  = 1'b0;
      flush_c   = 1'b0;
      state_nxt = RUN;
      if (!rstd) begin
         flush_c = 1'b1;
      end else if (hz.mem_busy) begin
         freeze_c  = 1'b1;
         stall_c   = 1'b1;
         state_nxt = MEMWAIT;
      end else if (take) begin
         flush_c = 1'b1;
      end else if (load_use && state != LDSTALL) begin
         stall_c   = 1'b1;
         bubble_c  = 1'b1;
         state_nxt = LDSTALL;
      end
   end

   assign hz.stall_if  = stall_c;
   assign hz.stall_id  = stall_c;
   assign hz.bubble_ex = bubble_c;
   assign hz.freeze    = freeze_c;
   assign hz.flush_if  = flush_c;
   assign hz.flush_id  = flush_c;

   // EX -> MEM -> WB shadow stage and forwarding select register
   always_ff @(posedge clk) begin
      if (!rstd) begin
         state       <= RUN;
         mem_dst_p1  <= '0;
         mem_wr_p1   <= 1'b0;
         mem_ld_p1   <= 1'b0;
         wb_dst_p2   <= '0;
         wb_wr_p2    <= 1'b0;
         wb_ld_p2    <= 1'b0;
         fwd_rs1_p1  <= 2'b00;
         fwd_rs2_p1  <= 2'b00;
         cnt_stall_q <= '0;
         cnt_flush_q <= '0;
      end else begin
         state <= state_nxt;
         if (stall_c) cnt_stall_q <= cnt_stall_q + 1'b1;
         if (flush_c) cnt_flush_q <= cnt_flush_q + 1'b1;
         if (!freeze_c) begin
            mem_dst_p1 <= (hz.ex_valid && !flush_c) ? hz.ex_dst : 5'd0;
            mem_wr_p1  <= hz.ex_valid & ~flush_c & hz.ex_wr;
            mem_ld_p1  <= hz.ex_valid & ~flush_c & hz.ex_is_load;
            wb_dst_p2  <= mem_dst_p1;
            wb_wr_p2   <= mem_wr_p1;
            wb_ld_p2   <= mem_ld_p1;
            if (bubble_c || flush_c) begin
               fwd_rs1_p1 <= 2'b00;
               fwd_rs2_p1 <= 2'b00;
            end else begin
               fwd_rs1_p1 <= fwd_sel(hz.id_rs1, hz.ex_valid & hz.ex_wr, hz.ex_dst,
                                     mem_wr_p1, mem_dst_p1);
               fwd_rs2_p1 <= fwd_sel(hz.id_rs2, hz.ex_valid & hz.ex_wr, hz.ex_dst,
                                     mem_wr_p1, mem_dst_p1);
            end
         end
      end
   end

   // Regfile is write-through, so the WB shadow never feeds a forwarding path
   assign unused_wb = ^{wb_dst_p2, wb_wr_p2, wb_ld_p2};

   assign hz.fwd_rs1   = fwd_rs1_p1;
   assign hz.fwd_rs2   = fwd_rs2_p1;
   assign hz.cnt_stall = cnt_stall_q;
   assign hz.cnt_flush = cnt_flush_q;
endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller: forwarding, load-use,
// branch flush, memory freeze, x0 handling and mid-operation reset.
module tb_hazard_controller;
   logic clk = 1'b0;
   logic rstd = 1'b0;
   int   total = 0;
   int   bad = 0;

   hazard_if #(.CNT_W(32)) hif ();
   hazard_controller #(.CNT_W(32)) dut (.clk(clk), .rstd(rstd), .hz(hif.slave));

   always #5 clk = ~clk;

   // {stall_if, stall_id, bubble_ex, freeze, flush_if, flush_id}
   logic [5:0] ctl;
   assign ctl = {hif.stall_if, hif.stall_id, hif.bubble_ex, hif.freeze, hif.flush_if, hif.flush_id};

   task automatic drive(input logic idv, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic exv, input logic [4:0] dst, input logic wr,
                        input logic ld, input logic tk, input logic busy);
      hif.id_valid   = idv;
      hif.id_rs1     = rs1;
      hif.id_rs2     = rs2;
      hif.ex_valid   = exv;
      hif.ex_dst     = dst;
      hif.ex_wr      = wr;
      hif.ex_is_load = ld;
      hif.ex_taken   = tk;
      hif.mem_busy   = busy;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstd = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      rstd = 1'b1;
   endtask

   task automatic test_reset();
      rstd = 1'b0;
      drive(1, 5, 7, 1, 7, 1, 1, 1, 1);
      total++;
      if (ctl !== 6'b000011) begin bad++; $display("FAIL reset_ctl: got %b want 000011", ctl); end
      tick();
      total++;
      if ({hif.fwd_rs1, hif.fwd_rs2} !== 4'b0000) begin
         bad++; $display("FAIL reset_fwd: got %b want 0000", {hif.fwd_rs1, hif.fwd_rs2});
      end
      total++;
      if (hif.cnt_stall !== 32'd0 || hif.cnt_flush !== 32'd0) begin
         bad++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", hif.cnt_stall, hif.cnt_flush);
      end
      rstd = 1'b1;
   endtask

   task automatic test_forward();
      do_reset();
      drive(1, 5, 3, 1, 5, 1, 0, 0, 0);  // add x5 in EX, ID reads x5
      total++;
      if (ctl !== 6'b000000) begin bad++; $display("FAIL fwd_ctl: got %b want 000000", ctl); end
      tick();
      total++;
      if ({hif.fwd_rs1, hif.fwd_rs2} !== 4'b0100) begin
         bad++; $display("FAIL fwd_ex: got %b want 0100", {hif.fwd_rs1, hif.fwd_rs2});
      end
      drive(1, 5, 6, 1, 6, 1, 0, 0, 0);  // x5 now in MEM, x6 in EX
      tick();
      total++;
      if ({hif.fwd_rs1, hif.fwd_rs2} !== 4'b1001) begin
         bad++; $display("FAIL fwd_mem: got %b want 1001", {hif.fwd_rs1, hif.fwd_rs2});
      end
      drive(1, 5, 6, 0, 0, 0, 0, 0, 0);  // x5 in WB (no path), x6 in MEM
      tick();
      total++;
      if ({hif.fwd_rs1, hif.fwd_rs2} !== 4'b0010) begin
         bad++; $display("FAIL fwd_wb: got %b want 0010", {hif.fwd_rs1, hif.fwd_rs2});
      end
   endtask

   task automatic test_load_use();
      do_reset();
      drive(1, 0, 7, 1, 7, 1, 1, 0, 0);  // lw x7 in EX, ID rs2=7
      total++;
      if (ctl !== 6'b111000) begin bad++; $display("FAIL lu_ctl: got %b want 111000", ctl); end
      tick();
      total++;
      if (hif.cnt_stall !== 32'd1 || hif.fwd_rs2 !== 2'b00) begin
         bad++; $display("FAIL lu_stall: got cnt=%0d fwd=%b want cnt=1 fwd=00", hif.cnt_stall, hif.fwd_rs2);
      end
      drive(1, 0, 7, 0, 0, 0, 0, 0, 0);  // bubble in EX
      total++;
      if (ctl !== 6'b000000) begin bad++; $display("FAIL lu_after_ctl: got %b want 000000", ctl); end
      tick();
      total++;
      if (hif.fwd_rs2 !== 2'b10 || hif.cnt_stall !== 32'd1) begin
         bad++; $display("FAIL lu_fwd: got fwd=%b cnt=%0d want fwd=10 cnt=1", hif.fwd_rs2, hif.cnt_stall);
      end
   endtask

   task automatic test_ldstall_one_cycle();
      do_reset();
      drive(1, 7, 0, 1, 7, 1, 1, 0, 0);
      tick();
      total++;
      if (ctl !== 6'b000000) begin bad++; $display("FAIL ld_suppress: got %b want 000000", ctl); end
      tick();
      total++;
      if (ctl !== 6'b111000) begin bad++; $display("FAIL ld_rearm: got %b want 111000", ctl); end
      tick();
      total++;
      if (hif.cnt_stall !== 32'd2) begin bad++; $display("FAIL ld_cnt: got %0d want 2", hif.cnt_stall); end
   endtask

   task automatic test_branch();
      do_reset();
      drive(1, 0, 7, 0, 7, 1, 0, 1, 0);  // taken but EX invalid
      total++;
      if (ctl !== 6'b000000) begin bad++; $display("FAIL br_invalid: got %b want 000000", ctl); end
      drive(1, 0, 7, 1, 7, 1, 1, 1, 0);  // taken with load-use present
      total++;
      if (ctl !== 6'b000011) begin bad++; $display("FAIL br_ctl: got %b want 000011", ctl); end
      tick();
      total++;
      if (hif.cnt_flush !== 32'd1 || hif.cnt_stall !== 32'd0) begin
         bad++; $display("FAIL br_cnt: got %0d/%0d want flush=1 stall=0", hif.cnt_flush, hif.cnt_stall);
      end
      drive(1, 7, 0, 0, 0, 0, 0, 0, 0);  // flushed instr must not sit in the MEM shadow
      tick();
      total++;
      if (hif.fwd_rs1 !== 2'b00) begin bad++; $display("FAIL br_shadow: got %b want 00", hif.fwd_rs1); end
   endtask

   task automatic test_mem_busy();
      do_reset();
      drive(1, 9, 0, 1, 9, 1, 0, 0, 0);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 0, 1, 0, 0, 0, 1, 1);
         total++;
         if (ctl !== 6'b110100) begin bad++; $display("FAIL busy_ctl%0d: got %b want 110100", i, ctl); end
         tick();
      end
      total++;
      if (hif.fwd_rs1 !== 2'b01 || hif.cnt_stall !== 32'd3 || hif.cnt_flush !== 32'd0) begin
         bad++; $display("FAIL busy_hold: got fwd=%b stall=%0d flush=%0d want 01/3/0",
                         hif.fwd_rs1, hif.cnt_stall, hif.cnt_flush);
      end
      drive(1, 0, 0, 1, 0, 0, 0, 1, 0);
      total++;
      if (ctl !== 6'b000011) begin bad++; $display("FAIL busy_release: got %b want 000011", ctl); end
      tick();
      total++;
      if (hif.cnt_flush !== 32'd1 || hif.cnt_stall !== 32'd3) begin
         bad++; $display("FAIL busy_cnt: got flush=%0d stall=%0d want 1/3", hif.cnt_flush, hif.cnt_stall);
      end
   endtask

   task automatic test_x0();
      do_reset();
      drive(1, 0, 0, 1, 0, 1, 1, 0, 0);
      total++;
      if (ctl !== 6'b000000) begin bad++; $display("FAIL x0_ctl: got %b want 000000", ctl); end
      tick();
      total++;
      if (hif.fwd_rs1 !== 2'b00 || hif.cnt_stall !== 32'd0) begin
         bad++; $display("FAIL x0_fwd: got fwd=%b cnt=%0d want 00/0", hif.fwd_rs1, hif.cnt_stall);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      drive(1, 7, 0, 1, 7, 1, 1, 0, 0);
      tick();  // now in LDSTALL
      rstd = 1'b0;
      drive(1, 7, 0, 1, 7, 1, 1, 0, 0);
      total++;
      if (ctl !== 6'b000011) begin bad++; $display("FAIL rmid_ctl: got %b want 000011", ctl); end
      tick();
      total++;
      if (hif.cnt_stall !== 32'd0 || hif.cnt_flush !== 32'd0) begin
         bad++; $display("FAIL rmid_cnt: got %0d/%0d want 0/0", hif.cnt_stall, hif.cnt_flush);
      end
      rstd = 1'b1;
      drive(1, 7, 0, 1, 7, 1, 1, 0, 0);
      total++;
      if (ctl !== 6'b111000) begin bad++; $display("FAIL rmid_run: got %b want 111000", ctl); end
      tick();
      do_reset();
      drive(1, 0, 0, 1, 9, 1, 0, 0, 0);
      tick();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 1);  // enter MEMWAIT
      tick();
      rstd = 1'b0;
      drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
      tick();
      rstd = 1'b1;
      drive(1, 9, 0, 0, 0, 0, 0, 0, 0);
      total++;
      if (ctl !== 6'b000000) begin bad++; $display("FAIL rfrz_ctl: got %b want 000000", ctl); end
      tick();
      total++;
      if (hif.fwd_rs1 !== 2'b00) begin bad++; $display("FAIL rfrz_shadow: got %b want 00", hif.fwd_rs1); end
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      test_reset();
      test_forward();
      test_load_use();
      test_ldstall_one_cycle();
      test_branch();
      test_mem_busy();
      test_x0();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
